// File: rtl/multiple_seq.sv
// Load/store-multiple sequencer: accepts an LDM/STM/PUSH/POP request and issues
// one word transfer per cycle in ascending register order, then a base writeback.
module multiple_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [8:0]  reg_list,
  input  logic [3:0]  base_idx,
  input  logic [31:0] base_val,
  output logic        busy,
  output logic        w_mem_en_from_multiple,
  output logic        w_reg_en_from_multiple,
  output logic [3:0]  addr_i,
  output logic [31:0] addr_dm_out,
  output logic [31:0] bit_count_number,
  output logic        base_wb_en,
  output logic [3:0]  base_wb_addr,
  output logic [31:0] base_wb_data,
  output logic        done
);

  localparam logic [1:0] OP_STM  = 2'b00;
  localparam logic [1:0] OP_LDM  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

  state_t      state_reg;
  logic        is_load_reg;
  logic [3:0]  base_idx_reg;
  logic [15:0] list_reg;          // transfers still pending after the current one
  logic [31:0] addr_reg;          // address of the next pending transfer
  logic [31:0] final_base_reg;
  logic        wb_pending_reg;

  logic        mem_en_reg;
  logic        reg_en_reg;
  logic [3:0]  addr_i_reg;
  logic [31:0] addr_dm_reg;
  logic [31:0] bit_count_reg;
  logic        wb_en_reg;
  logic [3:0]  wb_addr_reg;
  logic [31:0] wb_data_reg;
  logic        done_reg;

  logic [8:0]  masked_list;
  logic [15:0] mapped_list;
  logic [3:0]  start_cnt;
  logic [31:0] start_span;
  logic [31:0] start_addr;
  logic [31:0] start_final;
  logic        start_wb_en;
  logic [3:0]  first_idx;
  logic [15:0] first_rest;
  logic [3:0]  next_idx;
  logic [15:0] next_rest;

  function automatic logic [3:0] lowest_idx(input logic [15:0] m);
    lowest_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_idx = 4'(i);
    end
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] m);
    popcount9 = 4'd0;
    for (int i = 0; i < 9; i++) begin
      popcount9 = popcount9 + {3'd0, m[i]};
    end
  endfunction

  // Bit 8 is only meaningful for PUSH (LR) and POP (PC).
  assign masked_list = op[1] ? reg_list : {1'b0, reg_list[7:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_low_regs
      assign mapped_list[gi] = masked_list[gi];
    end
  endgenerate
  assign mapped_list[13:8] = 6'd0;
  assign mapped_list[14]   = (op == OP_PUSH) && masked_list[8];
  assign mapped_list[15]   = (op == OP_POP)  && masked_list[8];

  always_comb begin
    start_cnt   = popcount9(masked_list);
    start_span  = {26'd0, start_cnt, 2'b00};
    start_addr  = (op == OP_PUSH) ? (base_val - start_span) : base_val;
    start_final = (op == OP_PUSH) ? (base_val - start_span) : (base_val + start_span);
    // LDM that loads its own base keeps the loaded value.
    start_wb_en = (start_cnt != 4'd0) &&
                  !((op == OP_LDM) && !base_idx[3] && masked_list[base_idx[2:0]]);
    first_idx   = lowest_idx(mapped_list);
    first_rest  = mapped_list & (mapped_list - 16'd1);
    next_idx    = lowest_idx(list_reg);
    next_rest   = list_reg & (list_reg - 16'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      is_load_reg    <= 1'b0;
      base_idx_reg   <= 4'd0;
      list_reg       <= 16'd0;
      addr_reg       <= 32'd0;
      final_base_reg <= 32'd0;
      wb_pending_reg <= 1'b0;
      mem_en_reg     <= 1'b0;
      reg_en_reg     <= 1'b0;
      addr_i_reg     <= 4'd0;
      addr_dm_reg    <= 32'd0;
      bit_count_reg  <= 32'd0;
      wb_en_reg      <= 1'b0;
      wb_addr_reg    <= 4'd0;
      wb_data_reg    <= 32'd0;
      done_reg       <= 1'b0;
    end else begin
      mem_en_reg  <= 1'b0;
      reg_en_reg  <= 1'b0;
      addr_i_reg  <= 4'd0;
      addr_dm_reg <= 32'd0;
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= 4'd0;
      wb_data_reg <= 32'd0;
      done_reg    <= 1'b0;

      unique case (state_reg)
        IDLE: begin
          if (start) begin
            is_load_reg    <= op[0];
            base_idx_reg   <= base_idx;
            final_base_reg <= start_final;
            wb_pending_reg <= start_wb_en;
            bit_count_reg  <= {26'd0, start_cnt, 2'b00};
            if (start_cnt != 4'd0) begin
              state_reg   <= XFER;
              mem_en_reg  <= ~op[0];
              reg_en_reg  <= op[0];
              addr_i_reg  <= first_idx;
              addr_dm_reg <= start_addr;
              addr_reg    <= start_addr + 32'd4;
              list_reg    <= first_rest;
            end else begin
              state_reg   <= FINISH;
              list_reg    <= 16'd0;
              done_reg    <= 1'b1;
              wb_addr_reg <= base_idx;
              wb_data_reg <= start_final;
            end
          end
        end

        XFER: begin
          if (list_reg == 16'd0) begin
            state_reg   <= FINISH;
            done_reg    <= 1'b1;
            wb_en_reg   <= wb_pending_reg;
            wb_addr_reg <= base_idx_reg;
            wb_data_reg <= final_base_reg;
          end else begin
            mem_en_reg  <= ~is_load_reg;
            reg_en_reg  <= is_load_reg;
            addr_i_reg  <= next_idx;
            addr_dm_reg <= addr_reg;
            addr_reg    <= addr_reg + 32'd4;
            list_reg    <= next_rest;
          end
        end

        FINISH: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy                   = (state_reg != IDLE);
  assign w_mem_en_from_multiple = mem_en_reg;
  assign w_reg_en_from_multiple = reg_en_reg;
  assign addr_i                 = addr_i_reg;
  assign addr_dm_out            = addr_dm_reg;
  assign bit_count_number       = bit_count_reg;
  assign base_wb_en             = wb_en_reg;
  assign base_wb_addr           = wb_addr_reg;
  assign base_wb_data           = wb_data_reg;
  assign done                   = done_reg;

endmodule

// File: tb/tb_multiple_seq.sv
// Directed bench for multiple_seq: a reference model queues the expected output
// of every cycle of an operation, which is then compared cycle by cycle.
module tb_multiple_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [8:0]  reg_list;
  logic [3:0]  base_idx;
  logic [31:0] base_val;
  logic        busy;
  logic        w_mem_en_from_multiple;
  logic        w_reg_en_from_multiple;
  logic [3:0]  addr_i;
  logic [31:0] addr_dm_out;
  logic [31:0] bit_count_number;
  logic        base_wb_en;
  logic [3:0]  base_wb_addr;
  logic [31:0] base_wb_data;
  logic        done;

  typedef struct packed {
    logic        busy;
    logic        mem_en;
    logic        reg_en;
    logic [3:0]  addr_i;
    logic [31:0] addr_dm;
    logic [31:0] bit_count;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        done;
  } obs_t;

  obs_t observed;
  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  multiple_seq dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .op                     (op),
    .reg_list               (reg_list),
    .base_idx               (base_idx),
    .base_val               (base_val),
    .busy                   (busy),
    .w_mem_en_from_multiple (w_mem_en_from_multiple),
    .w_reg_en_from_multiple (w_reg_en_from_multiple),
    .addr_i                 (addr_i),
    .addr_dm_out            (addr_dm_out),
    .bit_count_number       (bit_count_number),
    .base_wb_en             (base_wb_en),
    .base_wb_addr           (base_wb_addr),
    .base_wb_data           (base_wb_data),
    .done                   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign observed = '{busy, w_mem_en_from_multiple, w_reg_en_from_multiple, addr_i,
                      addr_dm_out, bit_count_number, base_wb_en, base_wb_addr,
                      base_wb_data, done};

  function automatic obs_t idle_rec(input logic [31:0] bc);
    obs_t r;
    r = '0;
    r.bit_count = bc;
    return r;
  endfunction

  task automatic check(input string tag, input obs_t exp);
    checks++;
    assert (observed === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, exp);
      end
    $display("check %s busy=%0b mem=%0b reg=%0b ai=%0d adr=%h bc=%0d wb=%0b/%0d/%h done=%0b",
             tag, busy, w_mem_en_from_multiple, w_reg_en_from_multiple, addr_i,
             addr_dm_out, bit_count_number, base_wb_en, base_wb_addr, base_wb_data, done);
  endtask

  // glitch_at: cycle to pulse a bogus start; rst_at: cycle to assert reset (0 = none)
  task automatic run_op(input string name, input logic [1:0] o, input logic [8:0] l,
                        input logic [3:0] bi, input logic [31:0] bv,
                        input int glitch_at, input int rst_at);
    logic [8:0]  m;
    int          cnt;
    logic [31:0] a;
    logic [31:0] fin;
    logic [31:0] bc;
    logic        store;
    obs_t        r;
    int          cyc;

    m     = o[1] ? l : {1'b0, l[7:0]};
    cnt   = $countones(m);
    bc    = 32'(4 * cnt);
    store = (o == 2'b00) || (o == 2'b10);
    a     = (o == 2'b10) ? bv - bc : bv;
    fin   = (o == 2'b10) ? bv - bc : bv + bc;

    for (int i = 0; i < 9; i++) begin
      if (m[i]) begin
        r = idle_rec(bc);
        r.busy    = 1'b1;
        r.mem_en  = store;
        r.reg_en  = !store;
        r.addr_i  = (i == 8) ? ((o == 2'b11) ? 4'd15 : 4'd14) : 4'(i);
        r.addr_dm = a;
        exp_q.push_back(r);
        a = a + 32'd4;
      end
    end
    r = idle_rec(bc);
    r.busy    = 1'b1;
    r.done    = 1'b1;
    r.wb_en   = (cnt != 0) && !((o == 2'b01) && (bi < 4'd8) && m[bi[2:0]]);
    r.wb_addr = bi;
    r.wb_data = fin;
    exp_q.push_back(r);
    exp_q.push_back(idle_rec(bc));
    if (rst_at > 0) begin
      while (exp_q.size() > rst_at) void'(exp_q.pop_back());
      exp_q.push_back(idle_rec(32'd0));
    end

    op = o; reg_list = l; base_idx = bi; base_val = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (cyc == glitch_at) begin
        start = 1'b1; op = 2'b00; reg_list = 9'h0FF; base_idx = 4'd3; base_val = 32'h5000;
      end
      if (cyc == rst_at) rst = 1'b1;
      check($sformatf("%s_c%0d", name, cyc), r);
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; reg_list = 9'd0; base_idx = 4'd0; base_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", idle_rec(32'd0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("stm",        2'b00, 9'h016, 4'd5,  32'h0000_0100, 0, 0);
    run_op("push",       2'b10, 9'h101, 4'd13, 32'h0000_0200, 0, 0);
    run_op("ldm",        2'b01, 9'h005, 4'd2,  32'h0000_0300, 0, 0);
    run_op("pop",        2'b11, 9'h180, 4'd13, 32'h0000_0400, 0, 0);
    run_op("stm_empty",  2'b00, 9'h000, 4'd5,  32'h0000_0100, 0, 0);
    run_op("ldm_masked", 2'b01, 9'h100, 4'd5,  32'h0000_0100, 0, 0);
    run_op("stm_glitch", 2'b00, 9'h0A1, 4'd1,  32'h0000_0800, 2, 0);
    run_op("stm_rst",    2'b00, 9'h00F, 4'd6,  32'h0000_0900, 0, 2);
    run_op("ldm_wrap",   2'b01, 9'h048, 4'd0,  32'hFFFF_FFFC, 0, 0);
    run_op("push_full",  2'b10, 9'h1FF, 4'd13, 32'h0000_1000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multiple_seq.md
# multiple_seq

Sequencer for Thumb load/store-multiple (LDM, STM, PUSH, POP) in the Cortex-M0 core. On a start pulse from decode it holds the pipeline and issues one word transfer per cycle into the execute stage. Each transfer drives `w_mem_en_from_multiple` or `w_reg_en_from_multiple`, `addr_i` and `addr_dm_out`. After the last transfer it requests the base-register writeback.

## Interface
- No parameters.
- `clk` input 1: core clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request from decode; condition already passed.
- `op` input 2: 00 STM, 01 LDM, 10 PUSH, 11 POP.
- `reg_list` input 9: bits [7:0] select R0–R7; bit 8 is LR for PUSH and PC for POP, and is ignored (masked) for LDM/STM.
- `base_idx` input 4: base register number; decode supplies 13 for PUSH/POP.
- `base_val` input 32: current base register value.
- `busy` output 1: high whenever state is not IDLE; stalls fetch/decode.
- `w_mem_en_from_multiple` output 1: store transfer this cycle.
- `w_reg_en_from_multiple` output 1: load transfer this cycle.
- `addr_i` output 4: register being transferred.
- `addr_dm_out` output 32: word address of the transfer.
- `bit_count_number` output 32: 4 × popcount(masked list), latched at accept.
- `base_wb_en` output 1: base writeback strobe.
- `base_wb_addr` output 4: base register to write.
- `base_wb_data` output 32: new base value.
- `done` output 1: one-cycle completion pulse.

## Operation
- **States:** IDLE, XFER, FINISH.
- **IDLE:**
  - When `start`=1, latch op, base_idx and masked list. Set cnt = popcount(list) (0..9) and bit_count_number = 4·cnt.
  - Start address: PUSH uses base_val − 4·cnt; all other ops use base_val.
  - Final base: PUSH uses base_val − 4·cnt; all other ops use base_val + 4·cnt.
  - Next state is XFER if cnt≠0, otherwise FINISH.
- **Bit-8 mapping:** maps to R14 for PUSH and R15 for POP.
- **XFER (one transfer per cycle):**
  - addr_i = lowest set bit of the remaining list.
  - addr_dm_out = current address.
  - Enable: w_mem_en_from_multiple for STM/PUSH, w_reg_en_from_multiple for LDM/POP.
  - At the clock edge: clear that bit and add 4 to the address (32-bit wrap).
  - When the cleared bit was the last one, go to FINISH.
- **Transfer order:** always ascending register number at ascending address, for all four ops.
- **FINISH (one cycle):**
  - `done`=1. `base_wb_addr` = latched base_idx. `base_wb_data` = final base.
  - `base_wb_en`=1 for STM, PUSH and POP.
  - `base_wb_en`=1 for LDM only if base_idx is not in the list.
  - Empty list: `base_wb_en`=0 and `done`=1.
  - Next state is IDLE.
- **Start while busy:** ignored; no queuing. Decode must not issue because `busy` stalls it.
- **Outputs outside XFER/FINISH:** enable and strobe outputs are 0. `addr_i`, `addr_dm_out` and `base_wb_*` are 0.
- **POP including PC:** the R15 write is an ordinary transfer with addr_i=15. The top level treats it as a branch.
- **Output timing:** all outputs are decoded from registered state only; none depends combinationally on `start`.

## Timing
- **Reset:** `rst` puts the block in IDLE. All outputs are 0, including `bit_count_number`.
- **Reset mid-operation:** a reset during XFER/FINISH aborts with no further enables. Already-issued writes are not undone.
- **Accept:** `start` is sampled in IDLE at cycle 0; `busy` rises at cycle 1.
- **Transfers:** N = cnt transfers occupy cycles 1..N. FINISH is cycle N+1; IDLE (`busy`=0) is cycle N+2.
- **Empty list:** FINISH at cycle 1.
- **Store timing:** data_mem writes on the clock edge ending each store cycle. Read data is combinational, so each load writes its register in the same cycle.
- **Back-to-back:** `start` may be accepted in the first IDLE cycle after FINISH.

## Test plan
- **STM R5!, {R1,R2,R4}, base_val=0x100:**
  - Cycles 1–3: w_mem_en with (addr_i, addr) = (1,0x100), (2,0x104), (4,0x108).
  - Cycle 4: done, base_wb_en, R5 ← 0x10C.
  - bit_count_number = 12.
- **PUSH {R0,LR}, SP=0x200:**
  - Transfers (0,0x1F8) then (14,0x1FC).
  - Writeback R13 ← 0x1F8. bit_count_number = 8.
- **LDM R2!, {R0,R2}, base 0x300:**
  - w_reg_en at (0,0x300) and (2,0x304).
  - FINISH has done=1 and base_wb_en=0.
- **POP {R7,PC}, SP=0x400:**
  - Loads (7,0x400) and (15,0x404).
  - R13 ← 0x408.
- **Empty list:** reg_list=0 with op=STM, base 0x100 → done at cycle 1, with no enables and no writeback. Also reg_list=0x100 with op=LDM is masked to empty and gives the same result.
- **Robustness:**
  - start pulsed during XFER is ignored.
  - rst asserted at cycle 2 of a 4-register STM → next cycle all outputs 0 and state IDLE; no done.
  - Base 0xFFFFFFFC with 2 registers → second address wraps to 0x00000000.
